// File: rtl/rol_iter_pkg.sv
// Shared constants for the iterative rotate-left unit: default widths and FSM encodings.
package rol_iter_pkg;

    localparam int OPERAND_WIDTH_DEF = 16;
    localparam int SHAMT_WIDTH_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ROT  = 2'b01,
        HOLD = 2'b10
    } rol_state_e;

endpackage

// File: rtl/rol_iter_if.sv
// Request/result handshake bundle between a producer/consumer (master) and rol_iter (slave).
interface rol_iter_if #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
) ();

    logic                     in_valid;
    logic [OPERAND_WIDTH-1:0] InBS;
    logic [SHAMT_WIDTH-1:0]   ShAmt;
    logic                     in_ready;
    logic                     out_valid;
    logic [OPERAND_WIDTH-1:0] OutBS;
    logic                     out_ready;
    logic                     busy;

    modport master (
        output in_valid, InBS, ShAmt, out_ready,
        input  in_ready, out_valid, OutBS, busy
    );

    modport slave (
        input  in_valid, InBS, ShAmt, out_ready,
        output in_ready, out_valid, OutBS, busy
    );

endinterface

// File: rtl/rol_iter_ctl.sv
// Control for rol_iter: FSM plus rotate down-counter, producing load/rotate enables
// for the datapath register and the registered handshake outputs.
module rol_iter_ctl
    import rol_iter_pkg::*;
#(
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    input  logic                   out_ready_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    output logic                   busy_o,
    output logic                   load_o,
    output logic                   rot_o
);

    rol_state_e             state_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    // Handshake outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= ROT;
                        cnt_q      <= shamt_i;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign load_o      = in_ready_q & in_valid_i;
    assign rot_o       = (state_q == ROT) && (cnt_q != '0);

endmodule

// File: rtl/rol_iter.sv
// Iterative rotate-left: rotates the captured operand one bit per cycle, ShAmt times,
// then holds the result until the consumer takes it.
module rol_iter
    import rol_iter_pkg::*;
#(
    parameter int OPERAND_WIDTH = OPERAND_WIDTH_DEF,
    parameter int SHAMT_WIDTH   = SHAMT_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    rol_iter_if.slave   bus
);

    logic [OPERAND_WIDTH-1:0] data_q;
    logic                     load;
    logic                     rot;

    rol_iter_ctl #(
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_ctl (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .out_ready_i (bus.out_ready),
        .shamt_i     (bus.ShAmt),
        .in_ready_o  (bus.in_ready),
        .out_valid_o (bus.out_valid),
        .busy_o      (bus.busy),
        .load_o      (load),
        .rot_o       (rot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= bus.InBS;
        end else if (rot) begin
            data_q <= {data_q[OPERAND_WIDTH-2:0], data_q[OPERAND_WIDTH-1]};
        end
    end

    assign bus.OutBS = data_q;

endmodule

// File: tb/tb_rol_iter.sv
// Self-checking bench for rol_iter: scoreboard of expected rotations, latency,
// hold stability, busy-time request rejection and asynchronous reset.
module tb_rol_iter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [15:0] exp_q[$];

    rol_iter_if #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) bus ();

    rol_iter #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
        logic [31:0] t;
        t = {x, x} << s;
        return t[31:16];
    endfunction

    // Present one request at a negedge so it is accepted on the following posedge.
    task automatic drive_request(input logic [15:0] x, input logic [3:0] s);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.InBS     = x;
        bus.ShAmt    = s;
        exp_q.push_back(rotl(x, int'(s)));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) cycles = 999;
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.OutBS !== 16'h0000) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b busy=%b out=%h expected 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.OutBS);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single(input logic [15:0] x, input logic [3:0] s, input logic [15:0] want, input string nm);
        int cyc;
        logic [15:0] e;
        drive_request(x, s);
        wait_out_valid(cyc);
        n_cmp++;
        if (cyc !== int'(s) + 1) begin
            n_err++;
            $display("[TB] FAIL %s_latency: got %0d expected %0d", nm, cyc, int'(s) + 1);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.OutBS !== want || bus.OutBS !== e) begin
            n_err++;
            $display("[TB] FAIL %s_data: got %h expected %h (model %h)", nm, bus.OutBS, want, e);
        end
        consume();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL %s_release: got rdy=%b busy=%b vld=%b expected 1 0 0",
                     nm, bus.in_ready, bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_hold();
        int cyc;
        logic [15:0] e;
        drive_request(16'hA5C3, 4'd3);
        wait_out_valid(cyc);
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.OutBS !== e) begin
                n_err++;
                $display("[TB] FAIL hold_stable[%0d]: got vld=%b out=%h expected 1 %h", i, bus.out_valid, bus.OutBS, e);
            end
        end
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL hold_release: got vld=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [15:0] e;
        drive_request(16'h1234, 4'd8);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.InBS     = 16'hFFFF;
        bus.ShAmt    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL busy_flags: got rdy=%b busy=%b expected 0 1", bus.in_ready, bus.busy);
        end
        bus.in_valid = 1'b0;
        wait_out_valid(cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.OutBS !== 16'h3412 || bus.OutBS !== e) begin
            n_err++;
            $display("[TB] FAIL busy_ignore_data: got %h expected 3412", bus.OutBS);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [15:0] e;
        logic [15:0] x;
        logic [3:0]  s;
        for (int k = 0; k < 6; k++) begin
            x = 16'($urandom);
            s = 4'($urandom_range(0, 15));
            drive_request(x, s);
            wait_out_valid(cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (cyc !== int'(s) + 1 || bus.OutBS !== e) begin
                n_err++;
                $display("[TB] FAIL b2b[%0d]: got lat=%0d out=%h expected lat=%0d out=%h", k, cyc, bus.OutBS, int'(s) + 1, e);
            end
            consume();
        end
    endtask

    task automatic test_reset_mid_rot();
        int pulses;
        drive_request(16'h0F0F, 4'd10);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.OutBS !== 16'h0000 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_mid_rot: got out=%h busy=%b rdy=%b vld=%b expected 0000 0 1 0",
                     bus.OutBS, bus.busy, bus.in_ready, bus.out_valid);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("[TB] FAIL reset_no_result: got %0d out_valid cycles expected 0", pulses);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        bus.in_valid  = 1'b0;
        bus.InBS      = '0;
        bus.ShAmt     = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single(16'h8001, 4'd1,  16'h0003, "rot1");
        test_single(16'h1234, 4'd4,  16'h2341, "rot4");
        test_single(16'hBEEF, 4'd0,  16'hBEEF, "rot0");
        test_single(16'h0001, 4'd15, 16'h8000, "rot15");
        test_hold();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_rot();
        test_single(16'hC001, 4'd2, 16'h0007, "after_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rol_iter.md
ROL_ITER -- requirements
Module: rol_iter

Interface
REQ-001 The block SHALL expose parameter OPERAND_WIDTH, default 16, the operand and result width in bits.
REQ-002 The block SHALL expose parameter SHAMT_WIDTH, default 4, the rotate-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present on InBS/ShAmt.
REQ-006 The block SHALL have port InBS, input, OPERAND_WIDTH bits: the operand to rotate left.
REQ-007 The block SHALL have port ShAmt, input, SHAMT_WIDTH bits: the rotate-left amount, 0..15.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: OutBS holds a completed result.
REQ-010 The block SHALL have port OutBS, output, OPERAND_WIDTH bits: the rotated result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: a request has been accepted and not yet consumed.

Function
REQ-013 Internal state SHALL be a data register, a SHAMT_WIDTH-bit down-counter, and an FSM with states IDLE, ROT and HOLD.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==HOLD); busy SHALL equal (state!=IDLE).
REQ-015 OutBS SHALL always drive the data register directly; it is meaningful only while out_valid=1.
REQ-016 Acceptance SHALL occur on an edge with in_valid=1 and in_ready=1: data<=InBS, cnt<=ShAmt, and state IDLE->ROT.
REQ-017 In ROT with cnt!=0, each edge SHALL apply data<={data[14:0],data[15]} (rotate left by 1) and cnt<=cnt-1.
REQ-018 In ROT with cnt==0, the next edge SHALL move state ROT->HOLD with data unchanged.
REQ-019 Latency SHALL be exactly ShAmt+1 cycles from the acceptance edge to out_valid rising; ShAmt=0 therefore gives 1 cycle with OutBS=InBS.
REQ-020 The final OutBS SHALL equal InBS rotated left by ShAmt, the exact inverse of the team's rotate-right unit for the same ShAmt.
REQ-021 In HOLD, out_valid and OutBS SHALL stay stable until an edge with out_ready=1, which moves state HOLD->IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; a request presented while busy is neither captured nor queued.
REQ-023 out_ready SHALL be ignored outside HOLD.
REQ-024 The earliest back-to-back acceptance SHALL be the edge after the HOLD->IDLE edge; the block holds one request at a time.
REQ-025 Counter arithmetic SHALL never underflow, because the decrement occurs only when cnt!=0.

Reset
REQ-026 Asserting rst SHALL immediately, without waiting for a clock edge, force state=IDLE, data=0 and cnt=0.
REQ-027 During reset the outputs SHALL be in_ready=1, out_valid=0, busy=0 and OutBS=0x0000.
REQ-028 Reset asserted in ROT or HOLD SHALL discard the in-flight request with no out_valid pulse.
REQ-029 The first acceptance after reset SHALL be possible on the first rising edge at which rst=0.

Structure
REQ-030 The FSM state encodings (IDLE=2'b00, ROT=2'b01, HOLD=2'b10) SHALL live in the shared project constants include/package, together with the default OPERAND_WIDTH/SHAMT_WIDTH.
REQ-031 One sub-module, rol_iter_ctl, SHALL contain the FSM and down-counter and drive a load enable and a rotate enable to the datapath register in rol_iter.
REQ-032 The encoding 2'b11 SHALL be unreachable and SHALL recover to IDLE on the next edge.

Verification
REQ-033 The bench SHALL check: InBS=0x8001, ShAmt=1 accepted -> out_valid 2 cycles later with OutBS=0x0003.
REQ-034 The bench SHALL check: InBS=0x1234, ShAmt=4 -> out_valid 5 cycles later with OutBS=0x2341; then ShAmt=0 with InBS=0xBEEF -> 1 cycle later with OutBS=0xBEEF.
REQ-035 The bench SHALL check: InBS=0x0001, ShAmt=15 -> out_valid 16 cycles later with OutBS=0x8000.
REQ-036 The bench SHALL check: out_ready held low 3 cycles in HOLD -> out_valid=1 and OutBS stable throughout, then IDLE the edge after out_ready=1.
REQ-037 The bench SHALL check: in_valid=1 with InBS=0xFFFF during ROT -> no capture, and the original result is unchanged.
REQ-038 The bench SHALL check: rst pulsed mid-ROT between edges -> OutBS=0, busy=0 and in_ready=1 immediately, and no out_valid follows.
